// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs req/ack data-memory transactions for loads and stores,
// stalls Execute while one is outstanding, and forwards results to Writeback.
module mem_access_stage #(
    parameter int REG_WD  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [REG_WD-1:0] ex_aluout,
    input  logic [REG_WD-1:0] ex_wdata,
    input  logic [2:0]        ex_dest,
    output logic              stall_ex,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [REG_WD-1:0] dmem_addr,
    output logic [REG_WD-1:0] dmem_wdata,
    input  logic [REG_WD-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [REG_WD-1:0] mem_data_read_in,
    output logic              wb_valid,
    output logic [REG_WD-1:0] wb_data,
    output logic [2:0]        wb_dest,
    output logic              err_timeout,
    output logic              err_illegal
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    // Abort fires on the edge where the counter shows TIMEOUT-1 un-acked cycles already elapsed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic              r_is_load;
    logic [2:0]        r_dest;
    logic              r_req;
    logic              r_we;
    logic [REG_WD-1:0] r_addr;
    logic [REG_WD-1:0] r_wdata;
    logic [REG_WD-1:0] r_rd_data;
    logic              r_wb_valid;
    logic [REG_WD-1:0] r_wb_data;
    logic [2:0]        r_wb_dest;
    logic              r_err_timeout;
    logic              r_err_illegal;

    logic w_alu_op;
    logic w_mem_op;
    logic w_bad_op;
    logic w_cnt_last;
    logic w_stall;

    assign w_alu_op   = ex_valid & ~ex_mem_rd & ~ex_mem_wr;
    assign w_mem_op   = ex_valid & (ex_mem_rd ^ ex_mem_wr);
    assign w_bad_op   = ex_valid & ex_mem_rd & ex_mem_wr;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_mem_op) w_next = S_WAIT;
            S_WAIT: if (dmem_ack || w_cnt_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall = (r_state == S_WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_dest        <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rd_data     <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_dest     <= '0;
            r_err_timeout <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_alu_op) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= ex_aluout;
                        r_wb_dest  <= ex_dest;
                    end else if (w_mem_op) begin
                        r_addr    <= ex_aluout;
                        r_wdata   <= ex_wdata;
                        r_dest    <= ex_dest;
                        r_is_load <= ex_mem_rd;
                        r_we      <= ex_mem_wr;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                    end else if (w_bad_op) begin
                        r_err_illegal <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (r_is_load) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= dmem_rdata;
                            r_wb_dest  <= r_dest;
                            r_rd_data  <= dmem_rdata;
                        end
                    end else if (w_cnt_last) begin
                        r_req         <= 1'b0;
                        r_err_timeout <= 1'b1;
                        if (r_is_load) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= '0;
                            r_wb_dest  <= r_dest;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_req <= 1'b0;
            endcase
        end
    end

    assign stall_ex         = w_stall;
    assign dmem_req         = r_req;
    assign dmem_we          = r_we;
    assign dmem_addr        = r_addr;
    assign dmem_wdata       = r_wdata;
    assign mem_data_read_in = r_rd_data;
    assign wb_valid         = r_wb_valid;
    assign wb_data          = r_wb_data;
    assign wb_dest          = r_wb_dest;
    assign err_timeout      = r_err_timeout;
    assign err_illegal      = r_err_illegal;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores, timeout, illegal op, reset abort.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [15:0] ex_aluout = '0;
    logic [15:0] ex_wdata = '0;
    logic [2:0]  ex_dest = '0;
    logic        stall_ex;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [15:0] mem_data_read_in;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_dest;
    logic        err_timeout;
    logic        err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.REG_WD(16), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_aluout(ex_aluout), .ex_wdata(ex_wdata), .ex_dest(ex_dest),
        .stall_ex(stall_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_data_read_in(mem_data_read_in),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
        .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        dmem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({stall_ex, dmem_req, dmem_we, wb_valid, err_timeout, err_illegal} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {stall_ex, dmem_req, dmem_we, wb_valid, err_timeout, err_illegal});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, mem_data_read_in, wb_data, wb_dest} !== 67'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h want all 0",
                     dmem_addr, dmem_wdata, mem_data_read_in, wb_data, wb_dest);
        end
    endtask

    task automatic test_alu();
        ex_valid = 1'b1; ex_aluout = 16'h1234; ex_dest = 3'd3;
        tick();
        idle_inputs();
        n_checks++;
        if ({wb_valid, wb_data, wb_dest, dmem_req, stall_ex} !== {1'b1, 16'h1234, 3'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_pass: got v=%b d=%h dst=%0d req=%b stall=%b want 1 1234 3 0 0",
                     wb_valid, wb_data, wb_dest, dmem_req, stall_ex);
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse: got wb_valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_aluout = 16'h1111; ex_dest = 3'd1;
        tick();
        ex_aluout = 16'h2222; ex_dest = 3'd2;
        n_checks++;
        if ({wb_valid, wb_data, wb_dest} !== {1'b1, 16'h1111, 3'd1}) begin
            n_fail++;
            $display("FAIL b2b_first: got %b %h %0d want 1 1111 1", wb_valid, wb_data, wb_dest);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({wb_valid, wb_data, wb_dest} !== {1'b1, 16'h2222, 3'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: got %b %h %0d want 1 2222 2", wb_valid, wb_data, wb_dest);
        end
        tick();
    endtask

    task automatic test_load_wait();
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_aluout = 16'h0040; ex_dest = 3'd6;
        tick();
        idle_inputs();
        ex_aluout = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({stall_ex, dmem_req, dmem_we, dmem_addr, wb_valid} !== {1'b1, 1'b1, 1'b0, 16'h0040, 1'b0}) begin
                n_fail++;
                $display("FAIL load_wait[%0d]: got stall=%b req=%b we=%b addr=%h wbv=%b want 1 1 0 0040 0",
                         i, stall_ex, dmem_req, dmem_we, dmem_addr, wb_valid);
            end
            if (i == 2) begin
                dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
            end
            tick();
        end
        dmem_ack = 1'b0;
        n_checks++;
        if ({wb_valid, wb_data, mem_data_read_in, wb_dest, stall_ex, dmem_req}
            !== {1'b1, 16'hBEEF, 16'hBEEF, 3'd6, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_done: got v=%b d=%h rd=%h dst=%0d stall=%b req=%b want 1 beef beef 6 0 0",
                     wb_valid, wb_data, mem_data_read_in, wb_dest, stall_ex, dmem_req);
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pulse: got wb_valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_store();
        ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_aluout = 16'h0010; ex_wdata = 16'h5A5A; ex_dest = 3'd7;
        dmem_ack = 1'b1;
        tick();
        // ALU op presented during WAIT must be ignored, then accepted at the next edge.
        ex_mem_wr = 1'b0; ex_aluout = 16'hABCD; ex_dest = 3'd5;
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_ex, wb_valid}
            !== {1'b1, 1'b1, 16'h0010, 16'h5A5A, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL store_req: got req=%b we=%b a=%h wd=%h stall=%b wbv=%b want 1 1 0010 5a5a 1 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_ex, wb_valid);
        end
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({dmem_req, stall_ex, wb_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_done: got req=%b stall=%b wbv=%b want 000", dmem_req, stall_ex, wb_valid);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({wb_valid, wb_data, wb_dest} !== {1'b1, 16'hABCD, 3'd5}) begin
            n_fail++;
            $display("FAIL store_next_op: got %b %h %0d want 1 abcd 5", wb_valid, wb_data, wb_dest);
        end
        tick();
    endtask

    task automatic test_timeout();
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_aluout = 16'h0080; ex_dest = 3'd2;
        tick();
        idle_inputs();
        for (int i = 1; i <= 14; i++) begin
            tick();
            n_checks++;
            if ({dmem_req, stall_ex, err_timeout, wb_valid} !== 4'b1100) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got req=%b stall=%b err=%b wbv=%b want 1100",
                         i, dmem_req, stall_ex, err_timeout, wb_valid);
            end
        end
        tick();
        n_checks++;
        if ({dmem_req, stall_ex, err_timeout, wb_valid, wb_data, wb_dest, mem_data_read_in}
            !== {1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3'd2, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL timeout_abort: got req=%b stall=%b err=%b v=%b d=%h dst=%0d rd=%h want 0 0 1 1 0000 2 beef",
                     dmem_req, stall_ex, err_timeout, wb_valid, wb_data, wb_dest, mem_data_read_in);
        end
        tick();
        n_checks++;
        if ({err_timeout, wb_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%b wbv=%b want 1 0", err_timeout, wb_valid);
        end
    endtask

    task automatic test_ack_on_last();
        do_reset();
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_aluout = 16'h0090; ex_dest = 3'd4;
        tick();
        idle_inputs();
        for (int i = 1; i <= 14; i++) tick();
        dmem_ack = 1'b1; dmem_rdata = 16'h1357;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({err_timeout, wb_valid, wb_data, mem_data_read_in, dmem_req}
            !== {1'b0, 1'b1, 16'h1357, 16'h1357, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_last: got err=%b v=%b d=%h rd=%h req=%b want 0 1 1357 1357 0",
                     err_timeout, wb_valid, wb_data, mem_data_read_in, dmem_req);
        end
        tick();
    endtask

    task automatic test_illegal();
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; ex_aluout = 16'h0100;
        tick();
        idle_inputs();
        n_checks++;
        if ({err_illegal, dmem_req, stall_ex, wb_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL illegal: got ill=%b req=%b stall=%b wbv=%b want 1000",
                     err_illegal, dmem_req, stall_ex, wb_valid);
        end
        tick();
        n_checks++;
        if ({err_illegal, dmem_req, wb_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL illegal_sticky: got ill=%b req=%b wbv=%b want 100", err_illegal, dmem_req, wb_valid);
        end
    endtask

    task automatic test_reset_midload();
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_aluout = 16'h0200; ex_dest = 3'd1;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if ({dmem_req, stall_ex, err_illegal} !== 3'b111) begin
            n_fail++;
            $display("FAIL midload_pre: got req=%b stall=%b ill=%b want 111", dmem_req, stall_ex, err_illegal);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({dmem_req, stall_ex, err_illegal, err_timeout, wb_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL midload_reset: got req=%b stall=%b ill=%b to=%b wbv=%b want 00000",
                     dmem_req, stall_ex, err_illegal, err_timeout, wb_valid);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({wb_valid, dmem_req, stall_ex, mem_data_read_in} !== {3'b000, 16'h0000}) begin
                n_fail++;
                $display("FAIL midload_late_ack[%0d]: got wbv=%b req=%b stall=%b rd=%h want 0 0 0 0000",
                         i, wb_valid, dmem_req, stall_ex, mem_data_read_in);
            end
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_wait();
        test_store();
        test_timeout();
        test_ack_on_last();
        test_illegal();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting directly downstream of the Execute stage. It takes the ALU result, store data and memory-enable controls produced by Execute, runs a req/ack transaction to the data memory for loads and stores, stalls Execute while the transaction is outstanding, and forwards results to Writeback. Load data is also returned to Execute on `mem_data_read_in`.

## Interface

Parameters:
- `REG_WD`, 16 (`REGISTER_WIDTH`): data and address width.
- `TIMEOUT`, 15: maximum number of cycles to wait for `dmem_ack` before aborting. Legal range 1..255.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  Execute presents an operation this cycle.
- `ex_mem_rd`  in  1  operation is a load.
- `ex_mem_wr`  in  1  operation is a store (the Execute `mem_write_en`).
- `ex_aluout`  in  REG_WD  ALU result; used as the memory address for loads and stores.
- `ex_wdata`  in  REG_WD  store data (the Execute `mem_data_write_out`).
- `ex_dest`  in  3  destination register for Writeback.
- `stall_ex`  out  1  Execute must hold its outputs.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  REG_WD  memory address.
- `dmem_wdata`  out  REG_WD  memory write data.
- `dmem_rdata`  in  REG_WD  memory read data; valid when `dmem_ack` = 1.
- `dmem_ack`  in  1  transaction complete.
- `mem_data_read_in`  out  REG_WD  last load data, returned to Execute.
- `wb_valid`  out  1  Writeback result valid; one-cycle pulse per result.
- `wb_data`  out  REG_WD  Writeback data.
- `wb_dest`  out  3  Writeback destination.
- `err_timeout`  out  1  sticky: a transaction was aborted.
- `err_illegal`  out  1  sticky: `ex_mem_rd` and `ex_mem_wr` were both set.

## Operation

- FSM states: IDLE, WAIT. Reset state is IDLE.
- Reset values: all outputs are 0. Reset clears the FSM, the counter and both sticky flags. An in-flight request is dropped immediately; no response is generated after reset releases.
- IDLE, with `ex_valid` = 0: nothing happens.
- IDLE, with `ex_valid` = 1 and neither rd nor wr set (ALU operation): pass-through. `wb_data` <= `ex_aluout`, `wb_dest` <= `ex_dest`, `wb_valid` <= 1. The FSM stays in IDLE.
- IDLE, with exactly one of rd or wr set:
  - Latch address, write data, dest and direction.
  - Drive `dmem_req` <= 1 and `dmem_we` <= `ex_mem_wr`.
  - Clear the counter and go to WAIT.
- IDLE, with both rd and wr set: `err_illegal` <= 1. The operation is dropped, with no memory access and no `wb_valid`.
- WAIT:
  - `stall_ex` = 1, decoded combinationally from the state.
  - `ex_valid` is ignored.
  - `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable.
  - The counter increments each cycle that `dmem_ack` = 0.
- WAIT, `dmem_ack` = 1, load:
  - `wb_data` and `mem_data_read_in` <= `dmem_rdata`.
  - `wb_valid` <= 1.
  - `dmem_req` <= 0, then go to IDLE.
- WAIT, `dmem_ack` = 1, store: `dmem_req` <= 0 and go to IDLE. `wb_valid` stays 0.
- WAIT, counter reaches `TIMEOUT` with no ack:
  - `err_timeout` <= 1 and `dmem_req` <= 0; go to IDLE.
  - A load additionally produces `wb_valid` <= 1 with `wb_data` = 0. `mem_data_read_in` is unchanged.
- If ack and timeout occur on the same edge, ack wins and `err_timeout` is not set.
- `dmem_ack` is ignored while in IDLE.
- `wb_valid` is 0 in every cycle not listed above. `wb_data` and `wb_dest` hold their last values.

## Timing

- Edge N accepts an operation (`ex_valid` sampled in IDLE).
- ALU pass-through: `wb_valid` is high during cycle N..N+1 only. Back-to-back ALU operations produce a `wb_valid` every cycle.
- Memory operation:
  - `dmem_req` and `stall_ex` rise after edge N.
  - Ack is sampled at edge M ≥ N+1. A zero-wait memory acks in the first req cycle, giving M = N+1.
  - After edge M, `dmem_req` and `stall_ex` are 0 and a load's `wb_valid` is high for one cycle.
  - Load latency, acceptance to `wb_valid`: M−N+1 edges. Minimum is 2.
- Next acceptance is at edge M+1 at the earliest, so there is one bubble after every memory operation.
- Timeout abort at edge N+`TIMEOUT` if no ack was sampled at edges N+1..N+`TIMEOUT`.
- `stall_ex` high spans exactly edges N+1..M (the WAIT cycles).

## Test plan

- Reset, then ALU op with `ex_aluout`=16'h1234 and `ex_dest`=3 → next cycle `wb_valid`=1, `wb_data`=16'h1234, `wb_dest`=3, `dmem_req`=0, `stall_ex`=0.
- Load from addr 16'h0040, ack after 3 WAIT cycles with `dmem_rdata`=16'hBEEF → `stall_ex` high for 3 cycles, `dmem_addr`=16'h0040 stable, then `wb_valid` pulse with `wb_data` = `mem_data_read_in` = 16'hBEEF.
- Store of 16'h5A5A to 16'h0010 with zero-wait ack → `dmem_we`=1 for one req cycle, no `wb_valid`, next op accepted 2 edges after the store.
- Load with no ack and `TIMEOUT`=15 → `dmem_req` drops after 15 WAIT cycles, `err_timeout`=1 sticky, `wb_valid` with `wb_data`=0. A second run with ack on the 15th cycle → no error, ack data returned.
- Both `ex_mem_rd` and `ex_mem_wr` set → `err_illegal`=1, no `dmem_req`, no `wb_valid`. Assert `reset` in WAIT mid-load → `dmem_req`, `stall_ex` and the errors clear immediately, and a late ack causes no `wb_valid`.
